traffic_phase_ctrl: RTL

- Sequences the signals of a two-road intersection, north-south (NS) and east-west (EW), plus one pedestrian crossing.
- Consumes the single-cycle 1 Hz `tick` from `clock_divider`.
- Holds each phase for a parameterised number of ticks and drives the lamp one-hots and the walk lamp.
- A latched pedestrian request may cut green short, never below a minimum, and inserts an all-vehicle-red walk phase.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/phase_timer.sv | 40 ++++
 rtl/traffic_phase_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller: phase encoding,
// lamp one-hots and the helper that sizes the phase timer.
package traffic_pkg;

  typedef enum logic [3:0] {
    NS_G  = 4'd0,
    NS_Y  = 4'd1,
    RED_A = 4'd2,
    PED_A = 4'd3,
    EW_G  = 4'd4,
    EW_Y  = 4'd5,
    RED_B = 4'd6,
    PED_B = 4'd7,
    FLASH = 4'd8
  } phase_e;

  // Lamp vectors are {R,Y,G}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic int max_dur(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for phase durations: loads duration-1 on phase entry and
// decrements on tick cycles, holding at zero until the next load.
module phase_timer #(
  parameter int W       = 5,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= W'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection sequencer with pedestrian walk phase.
// Optional night flashing mode is built only when NIGHT_FLASH_EN is defined.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_S     = 20,
  parameter int MIN_GREEN_S = 5,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 2,
  parameter int WALK_S      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  localparam int MAX_D = max_dur(GREEN_S, YELLOW_S, ALLRED_S, WALK_S);
  localparam int CW    = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CW-1:0] G_LD     = CW'(GREEN_S - 1);
  localparam logic [CW-1:0] Y_LD     = CW'(YELLOW_S - 1);
  localparam logic [CW-1:0] R_LD     = CW'(ALLRED_S - 1);
  localparam logic [CW-1:0] W_LD     = CW'(WALK_S - 1);
  localparam logic [CW-1:0] EARLY_TH = CW'(GREEN_S - MIN_GREEN_S);

  phase_e          state_q, state_d;
  logic            ped_q, ped_d;
  logic            load;
  logic [CW-1:0]   load_val;
  logic [CW-1:0]   count;
  logic            zero;
  logic            green_done;

  phase_timer #(.W(CW), .RST_VAL(GREEN_S - 1)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (count),
    .zero_o     (zero)
  );

  // A latched request may end green once the minimum has elapsed.
  assign green_done = zero || (ped_q && (count <= EARLY_TH));

  // NOTE: every signal written here gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        NS_G:  if (green_done) state_d = NS_Y;
        NS_Y:  if (zero)       state_d = RED_A;
        RED_A: begin
`ifdef NIGHT_FLASH_EN
          if (night)     state_d = FLASH;
          else
`endif
          if (zero)      state_d = ped_q ? PED_A : EW_G;
        end
        PED_A: if (zero)       state_d = EW_G;
        EW_G:  if (green_done) state_d = EW_Y;
        EW_Y:  if (zero)       state_d = RED_B;
        RED_B: begin
`ifdef NIGHT_FLASH_EN
          if (night)     state_d = FLASH;
          else
`endif
          if (zero)      state_d = ped_q ? PED_B : NS_G;
        end
        PED_B: if (zero)       state_d = NS_G;
`ifdef NIGHT_FLASH_EN
        FLASH: if (!night)     state_d = RED_B;
`endif
        default:               state_d = NS_G;
      endcase
    end
  end

  // Timer reloads on any phase entry with the new phase's duration.
  always_comb begin
    load     = (state_d != state_q);
    load_val = '0;
    case (state_d)
      NS_G, EW_G:   load_val = G_LD;
      NS_Y, EW_Y:   load_val = Y_LD;
      RED_A, RED_B: load_val = R_LD;
      PED_A, PED_B: load_val = W_LD;
      default:      load_val = '0;
    endcase
  end

  // Clearing on walk entry overrides a simultaneous request.
  always_comb begin
    ped_d = ped_q;
    if (ped_req && !(state_q inside {PED_A, PED_B})) ped_d = 1'b1;
    if ((state_d != state_q) && (state_d inside {PED_A, PED_B})) ped_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NS_G;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  logic flash_q, flash_d;

  always_comb begin
    flash_d = 1'b0;
    if ((state_q == FLASH) && (state_d == FLASH)) flash_d = flash_q ^ tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flash_q <= 1'b0;
    else        flash_q <= flash_d;
  end
`else
  logic unused_night;
  assign unused_night = night;
`endif

  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    walk     = 1'b0;
    case (state_q)
      NS_G:         ns_light = LAMP_G;
      NS_Y:         ns_light = LAMP_Y;
      EW_G:         ew_light = LAMP_G;
      EW_Y:         ew_light = LAMP_Y;
      PED_A, PED_B: walk     = 1'b1;
`ifdef NIGHT_FLASH_EN
      FLASH: begin
        ns_light = flash_q ? LAMP_Y : LAMP_OFF;
        ew_light = flash_q ? LAMP_R : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule
